fsm: RTL and testbench

FSM -- requirements
Module: fsm

---
 rtl/fsm_if.sv | 35 +++
 rtl/fsm.sv | 133 +++++++++++++
 tb/tb_fsm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fsm_if.sv
// ---------------------------------------------------------------------------
// fsm_if -- fare-gate handshake bundle.
//
// Groups the card-reader inputs and the gate/display outputs of the fare-gate
// controller so they travel as one port.
//   nfc          card-tap event, high for at least one cycle per tap
//   card_active  tapped card is valid (sampled with nfc)
//   fund_enough  tapped card balance covers the fare (sampled with nfc)
//   maintenance  gate out of service while high
//   open         gate door open command
//   reduce_bal   one-cycle fare-deduction strobe
//   disp         display code: 00 ready/maint, 01 invalid, 10 low funds, 11 open
//
// Modports: master drives the reader inputs and observes the gate outputs;
// slave is the gate controller.
// ---------------------------------------------------------------------------
interface fsm_if;
   logic       nfc;
   logic       card_active;
   logic       fund_enough;
   logic       maintenance;
   logic       open;
   logic       reduce_bal;
   logic [1:0] disp;

   modport master (
      output nfc, card_active, fund_enough, maintenance,
      input  open, reduce_bal, disp
   );

   modport slave (
      input  nfc, card_active, fund_enough, maintenance,
      output open, reduce_bal, disp
   );
endinterface

// File: rtl/fsm.sv
// ---------------------------------------------------------------------------
// fsm -- fare-gate controller (Moore machine).
//
// A tap in IDLE is classified as invalid card, insufficient funds or
// accepted. An accepted tap opens the gate for OPEN_CYCLES cycles and strobes
// reduce_bal once; a rejected tap shows an error code for ERR_CYCLES cycles.
// maintenance overrides everything and parks the gate closed in MAINT.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fsm_if.slave -- reader inputs in, open/reduce_bal/disp out
//
// Outputs are held in flops written alongside the state, so they change
// only on a clock edge (or immediately on reset) and never glitch with the
// asynchronous reader inputs.
// ---------------------------------------------------------------------------
module fsm #(
   parameter int unsigned OPEN_CYCLES = 4,
   parameter int unsigned ERR_CYCLES  = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   fsm_if.slave  bus
);

   // Counter holds (cycles - 1) at entry and counts down to zero, so a state
   // lasts exactly N cycles.
   localparam int unsigned MAX_CYC = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
   localparam int          CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYCLES - 1);
   localparam logic [CW-1:0] ERR_LOAD  = CW'(ERR_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [1:0] DISP_READY = 2'b00;
   localparam logic [1:0] DISP_INV   = 2'b01;
   localparam logic [1:0] DISP_FUND  = 2'b10;
   localparam logic [1:0] DISP_OPEN  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_OPEN     = 3'd1,
      S_ERR_INV  = 3'd2,
      S_ERR_FUND = 3'd3,
      S_MAINT    = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          open_q;
   logic          reduce_bal_q;
   logic [1:0]    disp_q;

   // NOTE: all state, counter and output flops use non-blocking assignments
   // so every register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         open_q       <= 1'b0;
         reduce_bal_q <= 1'b0;
         disp_q       <= DISP_READY;
      end else begin
         // The deduction strobe is only ever raised on the IDLE->OPEN edge.
         reduce_bal_q <= 1'b0;

         if (bus.maintenance) begin
            // Highest priority from every state, including a running OPEN.
            state  <= S_MAINT;
            cnt    <= '0;
            open_q <= 1'b0;
            disp_q <= DISP_READY;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (bus.nfc) begin
                     if (!bus.card_active) begin
                        // An invalid card is reported regardless of balance.
                        state  <= S_ERR_INV;
                        cnt    <= ERR_LOAD;
                        disp_q <= DISP_INV;
                     end else if (!bus.fund_enough) begin
                        state  <= S_ERR_FUND;
                        cnt    <= ERR_LOAD;
                        disp_q <= DISP_FUND;
                     end else begin
                        state        <= S_OPEN;
                        cnt          <= OPEN_LOAD;
                        open_q       <= 1'b1;
                        reduce_bal_q <= 1'b1;
                        disp_q       <= DISP_OPEN;
                     end
                  end
               end

               // Reader inputs are ignored while busy; only the timer matters.
               S_OPEN, S_ERR_INV, S_ERR_FUND: begin
                  if (cnt == '0) begin
                     state  <= S_IDLE;
                     open_q <= 1'b0;
                     disp_q <= DISP_READY;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end

               // maintenance is already known low here: leave on this edge.
               S_MAINT: begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  open_q <= 1'b0;
                  disp_q <= DISP_READY;
               end

               // NOTE: the three unused encodings fall back to IDLE so a
               // corrupted state register recovers within one edge.
               default: begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  open_q <= 1'b0;
                  disp_q <= DISP_READY;
               end
            endcase
         end
      end
   end

   assign bus.open       = open_q;
   assign bus.reduce_bal = reduce_bal_q;
   assign bus.disp       = disp_q;

endmodule

// File: tb/tb_fsm.sv
// ---------------------------------------------------------------------------
// tb_fsm -- directed self-checking bench for the fare-gate controller.
//
// Each step drives the reader inputs on the falling edge, pushes the outputs
// expected after the next rising edge onto a scoreboard queue, then pops and
// compares them 1 ns after that edge. Expected words are {open, reduce_bal,
// disp[1:0]} taken directly from the gate behaviour for the default
// OPEN_CYCLES = ERR_CYCLES = 4.
// ---------------------------------------------------------------------------
module tb_fsm;

   localparam logic [3:0] E_IDLE  = 4'b0000;  // closed, ready / maintenance
   localparam logic [3:0] E_OPEN1 = 4'b1111;  // first open cycle, fare strobe
   localparam logic [3:0] E_OPEN  = 4'b1011;  // open, no strobe
   localparam logic [3:0] E_INV   = 4'b0001;  // invalid card
   localparam logic [3:0] E_FUND  = 4'b0010;  // insufficient funds

   logic clk;
   logic rst_n;

   fsm_if bus ();

   fsm #(.OPEN_CYCLES(4), .ERR_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] sb_q[$];

   function automatic logic [3:0] observed();
      return {bus.open, bus.reduce_bal, bus.disp};
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed {open,rb,disp}=%b expected %b", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive inputs, queue the expectation, compare after the edge.
   task automatic step(input string tag, input logic nfc, input logic ca,
                       input logic fe, input logic mnt, input logic [3:0] exp);
      logic [3:0] want;
      bus.nfc         = nfc;
      bus.card_active = ca;
      bus.fund_enough = fe;
      bus.maintenance = mnt;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: scoreboard empty, observed %b", tag, observed());
      end else begin
         want = sb_q.pop_front();
         check(tag, observed(), want);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.nfc         = 1'b0;
      bus.card_active = 1'b0;
      bus.fund_enough = 1'b0;
      bus.maintenance = 1'b0;

      // Reset state before any clock edge.
      #2;
      check("reset_no_clk", observed(), E_IDLE);
      repeat (2) @(negedge clk);
      check("reset_held", observed(), E_IDLE);
      rst_n = 1'b1;

      // Idle with no tap.
      step("idle",        0, 0, 0, 0, E_IDLE);

      // Valid tap: one strobe, four open cycles, then ready.
      step("valid_c1",    1, 1, 1, 0, E_OPEN1);
      for (int i = 0; i < 3; i++) step("valid_cN", 0, 0, 0, 0, E_OPEN);
      step("valid_end",   0, 0, 0, 0, E_IDLE);

      // Invalid card, fund_enough is don't-care.
      step("inv_c1",      1, 0, 1, 0, E_INV);
      for (int i = 0; i < 3; i++) step("inv_cN", 0, 0, 0, 0, E_INV);
      step("inv_end",     0, 0, 0, 0, E_IDLE);

      // Insufficient funds.
      step("fund_c1",     1, 1, 0, 0, E_FUND);
      for (int i = 0; i < 3; i++) step("fund_cN", 0, 0, 0, 0, E_FUND);
      step("fund_end",    0, 0, 0, 0, E_IDLE);

      // Second valid tap during OPEN cycle 2: ignored, length unchanged.
      step("busy_c1",     1, 1, 1, 0, E_OPEN1);
      step("busy_tap2",   1, 1, 1, 0, E_OPEN);
      step("busy_c3",     0, 0, 0, 0, E_OPEN);
      step("busy_c4",     0, 0, 0, 0, E_OPEN);
      step("busy_end",    0, 0, 0, 0, E_IDLE);

      // Tap held through an error and past the return to IDLE is a new tap.
      step("hold_c1",     1, 0, 0, 0, E_INV);
      for (int i = 0; i < 3; i++) step("hold_cN", 1, 1, 1, 0, E_INV);
      step("hold_idle",   1, 1, 1, 0, E_IDLE);
      step("hold_newtap", 1, 1, 1, 0, E_OPEN1);
      for (int i = 0; i < 3; i++) step("hold_open", 0, 0, 0, 0, E_OPEN);
      step("hold_end",    0, 0, 0, 0, E_IDLE);

      // Maintenance blocks taps; exit edge ignores a simultaneous tap.
      step("maint_in",    0, 0, 0, 1, E_IDLE);
      step("maint_tap",   1, 1, 1, 1, E_IDLE);
      step("maint_tap2",  1, 1, 1, 1, E_IDLE);
      step("maint_exit",  1, 1, 1, 0, E_IDLE);
      step("post_maint",  1, 1, 1, 0, E_OPEN1);
      for (int i = 0; i < 3; i++) step("post_maint_open", 0, 0, 0, 0, E_OPEN);
      step("post_maint_end", 0, 0, 0, 0, E_IDLE);

      // Maintenance asserted in OPEN cycle 2 aborts the gate with no new strobe.
      step("abort_c1",    1, 1, 1, 0, E_OPEN1);
      step("abort_c2",    0, 0, 0, 1, E_IDLE);
      step("abort_hold",  0, 0, 0, 1, E_IDLE);
      step("abort_exit",  0, 0, 0, 0, E_IDLE);
      step("abort_idle",  0, 0, 0, 0, E_IDLE);

      // Reset in OPEN cycle 2 closes the gate without a clock.
      step("rst_c1",      1, 1, 1, 0, E_OPEN1);
      step("rst_c2",      0, 0, 0, 0, E_OPEN);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", observed(), E_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_release", 0, 0, 0, 0, E_IDLE);

      // Reset release then a tap on the very first edge is evaluated normally.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_first",   1, 1, 1, 0, E_OPEN1);
      for (int i = 0; i < 3; i++) step("rst_first_open", 0, 0, 0, 0, E_OPEN);
      step("rst_first_end", 0, 0, 0, 0, E_IDLE);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
